// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encodings and frame field sizes
package imem_loader_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;
  localparam int LEN_BYTES  = 2;
  localparam int CSUM_BYTES = 1;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: unpacks a framed byte stream into little-endian 32-bit imem writes
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit BOOT_HOLD      = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_WIDTH);
  state_t state, state_n;
  logic [7:0] len_lo, csum;
  logic [15:0] rem, n;
  logic [1:0] lane;
  logic [31:0] tcnt;
  logic acc, timeout, enter_lo;
  assign rx_ready = state inside {LEN_LO, LEN_HI, DATA, CHECK};
  assign busy = rx_ready;
  assign acc = rx_valid && rx_ready;
  assign n = {rx_data, len_lo};
  // LEN_LO waits forever; only the later frame fields are bounded in time
  assign timeout = (TIMEOUT_CYCLES != 0) && !acc && (state inside {LEN_HI, DATA, CHECK}) &&
                   (tcnt == 32'(TIMEOUT_CYCLES - 1));
  assign enter_lo = start && !busy;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = start ? LEN_LO : state;
      LEN_LO: state_n = acc ? LEN_HI : state;
      LEN_HI: state_n = !acc ? state : (n == 16'd0) ? CHECK : ({16'd0, n} > MAX_WORDS) ? ERROR : DATA;
      DATA: state_n = (acc && lane == 2'd3 && rem == 16'd1) ? CHECK : state;
      CHECK: state_n = !acc ? state : (rx_data == csum) ? DONE : ERROR;
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = ERROR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      words_loaded <= '0;
      done <= 1'b0;
      error <= 1'b0;
      cpu_hold <= BOOT_HOLD;
      len_lo <= '0;
      csum <= '0;
      rem <= '0;
      lane <= '0;
      tcnt <= '0;
    end else begin
      imem_we <= acc && state == DATA && lane == 2'd3;
      tcnt <= (acc || !busy || state == LEN_LO) ? 32'd0 : tcnt + 32'd1;
      if (imem_we) begin
        imem_waddr <= imem_waddr + ADDR_WIDTH'(1);
        words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
      end
      if (acc && state == LEN_LO) len_lo <= rx_data;
      if (acc && state == LEN_HI) rem <= n;
      if (acc && state == DATA) begin
        imem_wdata[{lane, 3'b000} +: 8] <= rx_data;
        lane <= lane + 2'd1;
        csum <= csum ^ rx_data;
        if (lane == 2'd3) rem <= rem - 16'd1;
      end
      if (enter_lo) begin
        done <= 1'b0;
        error <= 1'b0;
        words_loaded <= '0;
        imem_waddr <= '0;
        csum <= '0;
        lane <= '0;
        cpu_hold <= 1'b1;
      end
      if (state_n == DONE && state != DONE) begin
        done <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (state_n == ERROR && state != ERROR) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks with a write scoreboard for imem_loader
module tb_imem_loader;
  localparam int AW = 12;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic rx_ready, imem_we, busy, done, error, cpu_hold;
  logic [AW-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [AW:0] words_loaded;
  int total = 0, passed = 0;
  logic [AW+31:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .BOOT_HOLD(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      logic [AW+31:0] e;
      total++;
      if (exp_q.size() == 0) $display("FAIL write: unexpected addr=%0h data=%08h", imem_waddr, imem_wdata);
      else begin
        e = exp_q.pop_front();
        if ({imem_waddr, imem_wdata} !== e)
          $display("FAIL write: got addr=%0h data=%08h expected addr=%0h data=%08h",
                   imem_waddr, imem_wdata, e[AW+31:32], e[31:0]);
        else passed++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int maxgap, input int start_at);
    for (int i = 0; i < b.size(); i++) begin
      bit ok = 0;
      rx_valid = 1'b1;
      rx_data = b[i];
      start = (i == start_at);
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        ok = rx_ready;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!ok) begin
        total++;
        $display("FAIL accept: byte %0d not accepted within 50 cycles", i);
        break;
      end
      if (maxgap > 0) begin
        int g = $urandom_range(0, maxgap);
        rx_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w[$], input logic [7:0] csum_flip, input int maxgap,
                           input int start_at);
    logic [7:0] b[$];
    logic [7:0] cs = 8'd0;
    b.push_back(8'(w.size()));
    b.push_back(8'(w.size() >> 8));
    for (int i = 0; i < w.size(); i++) begin
      exp_q.push_back({AW'(i), w[i]});
      for (int k = 0; k < 4; k++) begin
        b.push_back(w[i][8*k +: 8]);
        cs ^= w[i][8*k +: 8];
      end
    end
    b.push_back(cs ^ csum_flip);
    pulse_start();
    send_bytes(b, maxgap, start_at);
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic h,
                              input int wl);
    total++;
    if ({done, error, cpu_hold, busy, words_loaded} !== {d, e, h, 1'b0, (AW+1)'(wl)})
      $display("FAIL %s: done=%b error=%b hold=%b busy=%b words=%0d expected %b %b %b 0 %0d",
               name, done, error, cpu_hold, busy, words_loaded, d, e, h, wl);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({rx_ready, imem_we, busy, done, error, cpu_hold, imem_waddr, imem_wdata, words_loaded} !== '0)
      $display("FAIL reset: ready=%b we=%b busy=%b done=%b err=%b hold=%b addr=%0h data=%0h words=%0d expected all zero",
               rx_ready, imem_we, busy, done, error, cpu_hold, imem_waddr, imem_wdata, words_loaded);
    else passed++;
  endtask

  task automatic test_good();
    run_frame('{32'h00000013, 32'h00100093}, 8'h00, 0, -1);
    check_status("good_frame", 1, 0, 0, 2);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b0) $display("FAIL ready_in_done: rx_ready=%b expected 0", rx_ready);
    else passed++;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bad_csum();
    run_frame('{32'h00000013, 32'h00100093}, 8'h01, 0, -1);
    check_status("bad_csum", 0, 1, 1, 2);
  endtask

  task automatic test_too_long();
    pulse_start();
    send_bytes('{8'h01, 8'h10}, 0, -1);
    check_status("too_long", 0, 1, 1, 0);
  endtask

  task automatic test_timeout();
    pulse_start();
    send_bytes('{8'h01, 8'h00, 8'hAA, 8'hBB}, 0, -1);
    repeat (15) begin @(posedge clk); #1; end
    total++;
    if ({busy, error} !== 2'b10) $display("FAIL timeout_early: busy=%b error=%b expected 1 0", busy, error);
    else passed++;
    @(posedge clk); #1;
    check_status("timeout", 0, 1, 1, 0);
  endtask

  task automatic test_gaps();
    logic [31:0] w[$];
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    run_frame(w, 8'h00, 0, -1);
    check_status("continuous", 1, 0, 0, 3);
    run_frame(w, 8'h00, 3, 7);
    check_status("gapped_start_ignored", 1, 0, 0, 3);
  endtask

  task automatic test_zero();
    run_frame('{}, 8'h00, 0, -1);
    check_status("zero_len", 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({AW'(0), 32'h44332211});
    pulse_start();
    send_bytes('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({rx_ready, imem_we, busy, done, error, cpu_hold, imem_waddr, imem_wdata, words_loaded} !== '0)
      $display("FAIL reset_mid: ready=%b we=%b busy=%b done=%b err=%b hold=%b addr=%0h data=%0h words=%0d expected all zero",
               rx_ready, imem_we, busy, done, error, cpu_hold, imem_waddr, imem_wdata, words_loaded);
    else passed++;
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (exp_q.size() != 0) $display("FAIL reset_mid_writes: %0d expected writes missing, need 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_full();
    logic [31:0] w[$];
    for (int i = 0; i < 2 ** AW; i++) w.push_back($urandom);
    run_frame(w, 8'h00, 0, -1);
    check_status("full_depth", 1, 0, 0, 2 ** AW);
    total++;
    if (imem_waddr !== '0) $display("FAIL full_wrap: waddr=%0h expected 0", imem_waddr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_too_long();
    test_timeout();
    test_gaps();
    test_zero();
    test_reset_mid();
    test_full();
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d writes missing, need 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
